image_scale_core: RTL and testbench
===================================

# image_scale_core

Frame-level image rescaling engine: walks a source image stored row-major in an external read memory, applies one of four scaling algorithms and writes the result row-major into an external write memory. It sits between the input frame buffer (ROM/RAM, 1-cycle read latency) and the output frame buffer. It contains the row/column/address generator and the pixel arithmetic unit, runs one frame after reset release, and then raises `frame_done`.

## Interface
- `ADDR_W`, 16, width of read/write addresses and of row/col counters
- `PIX_W`, 8, pixel width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `algo_sel`  in  2  0 block average, 1 NN zoom-in, 2 NN zoom-out, 3 pixel replication
- `factor_in_sel`  in  2  zoom-in factor Fi: 00→2, 01→4, 10→8, 11→2
- `factor_out_sel`  in  2  zoom-out factor Fo: same encoding
- `width`, `height`  in  10 each  source dimensions W, H
- `rd_addr`  out  ADDR_W  source read address
- `rd_data`  in  PIX_W  source pixel, valid 1 cycle after `rd_addr`
- `wr_addr`  out  ADDR_W  destination address
- `wr_data`  out  PIX_W  destination pixel
- `wr_en`  out  1  write strobe, one cycle per pixel
- `row`, `col`  out  ADDR_W  current destination-unit coordinates
- `frame_done`  out  1  sticky end-of-frame flag

## Operation
- All configuration inputs are sampled at reset release and held constant for the frame. `k` = log2(F).
- Destination size:
  - Zoom-in algorithms (1, 3): NW = W·Fi, NH = H·Fi.
  - Zoom-out algorithms (0, 2): NW = W/Fo, NH = H/Fo, truncated.
- Address: `rd_addr = r·W + c` and `wr_addr = R·NW + C`, both truncated mod 2^ADDR_W. No bounds check.
- Iteration order: units in row-major order (`col` fastest), then rows. `row`/`col` hold the unit's coordinates.
- Algorithms:
  - Block average (0): unit = destination pixel (R,C). Read Fo² samples at (R·Fo+dy, C·Fo+dx), dx fastest, into a 16-bit sum. Output = sum >> 2k.
  - NN zoom-in (1): unit = destination pixel (R,C). Read source (R>>k, C>>k) and write it once.
  - NN zoom-out (2): unit = destination pixel (R,C). Read source (R·Fo, C·Fo) and write it once.
  - Replication (3): unit = source pixel (r,c). Read it once, then write Fi² pixels at (r·Fi+dy, c·Fi+dx), dx fastest.
- FSM states:
  - RUN: issue reads, accumulate or capture data.
  - WRITE: pulse `wr_en`.
  - NEXT: advance `col`/`row`.
  - DONE: terminal.
  - After the last unit the FSM goes DONE. `frame_done` = 1 and stays 1 until `rst`.
- Zero destination size (NW = 0 or NH = 0, e.g. W=4 with Fo=8): go DONE on the first cycle after reset release, with no writes.

## Timing
- Reset values: all outputs 0, `frame_done` 0.
- Per-unit cycle counter `cntr` (7 bits) starts at 0.
- Block average: reads at cntr 0..Fo²−1, accumulate at 1..Fo², `wr_en` at Fo²+1. Unit length Fo²+2 cycles.
- NN (1, 2): read at 0, capture at 1, `wr_en` at 2. Unit length 3 cycles.
- Replication: read at 0, capture at 1, `wr_en` at cycles 2..Fi²+1. Unit length Fi²+2 cycles.
- The next unit's cycle 0 immediately follows the last cycle of the previous unit. There are no idle cycles.
- `frame_done` rises on the cycle after the final `wr_en`.
- `rst` mid-frame: `wr_en`, counters and `frame_done` clear immediately; the frame restarts from (0,0) after release.

## Configuration
- `BLOCK_AVG_ROUND_EN`:
  - Defined: block average output = (sum + 2^(2k−1)) >> 2k, round-half-up.
  - Undefined: truncation.
  - Other algorithms are unaffected.

## Structure
- Package `image_scale_pkg`:
  - algorithm encoding constants
  - FSM state enum
  - factor-decode function (sel → F, k)
  - `ADDR_W` / `PIX_W` defaults
- One sub-module, `scale_addr_gen`: `row`/`col`/`cntr` counters, dx/dy extraction from `cntr`, read/write address computation, DONE detection.
- The top level holds the sum/capture register, write datapath and FSM.

## Test plan
All scenarios use W=4, H=2 with source[i] = i+1.
- Replication, Fi=2: out[0]=out[1]=out[8]=out[9]=1, out[2]=2, out[31]=8. 8 units × 6 cycles; `frame_done` after the 32nd write.
- NN zoom-in, Fi=4 (16×8 destination): out[0..3]=1, out[4]=2, out[16]=1, out[64]=5, out[127]=8. 128 writes.
- NN zoom-out, Fo=2: exactly 2 writes, out[0]=1, out[1]=3.
- Block average, Fo=2: out[0]=3, out[1]=5. With `BLOCK_AVG_ROUND_EN`: out[0]=4, out[1]=6.
- Fo=8 zoom-out (zero size): `frame_done` on the first cycle after release, `wr_en` never asserted.
- `rst` pulsed after 10 cycles of replication: `wr_en`=0 and `frame_done`=0 during reset; the full, correct frame completes afterward.

Source files
------------

// File: rtl/image_scale_pkg.sv
// Shared types and constants for the image scaling engine.
package image_scale_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_PIX_W  = 8;

  localparam logic [1:0] ALGO_BLK_AVG = 2'd0;
  localparam logic [1:0] ALGO_NN_IN   = 2'd1;
  localparam logic [1:0] ALGO_NN_OUT  = 2'd2;
  localparam logic [1:0] ALGO_REPL    = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [3:0] f;
    logic [1:0] k;
  } factor_t;

  function automatic factor_t decode_factor(input logic [1:0] sel);
    factor_t r;
    case (sel)
      2'b01:   r = '{f: 4'd4, k: 2'd2};
      2'b10:   r = '{f: 4'd8, k: 2'd3};
      default: r = '{f: 4'd2, k: 2'd1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/image_scale_core_if.sv
// Source-read / destination-write memory bus of the scaling engine.
interface image_scale_core_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_en;

  modport master (output rd_addr, wr_addr, wr_data, wr_en, input rd_data);
  modport slave  (input rd_addr, wr_addr, wr_data, wr_en, output rd_data);
endinterface

// File: rtl/image_scale_core_addr_gen.sv
// Unit row/col/cycle counters, sub-pixel offsets and read/write addresses.
module scale_addr_gen
  import image_scale_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        algo_sel,
  input  logic [1:0]        factor_in_sel,
  input  logic [1:0]        factor_out_sel,
  input  logic [9:0]        width,
  input  logic [9:0]        height,
  input  logic              step,
  input  logic              advance,
  output logic [6:0]        cntr,
  output logic [1:0]        shift_k,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_unit,
  output logic              zero_size
);

  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic [6:0]        cntr_q, cntr_d;
  logic              zoom_in;
  factor_t           fac;
  logic [ADDR_W-1:0] w_ext, h_ext, nw, nh, unit_w, unit_h, dx, dy;
  logic [6:0]        idx, mask;

  always_comb begin
    zoom_in = (algo_sel == ALGO_NN_IN) || (algo_sel == ALGO_REPL);
    fac     = zoom_in ? decode_factor(factor_in_sel) : decode_factor(factor_out_sel);
    w_ext   = ADDR_W'(width);
    h_ext   = ADDR_W'(height);
    nw      = zoom_in ? (w_ext << fac.k) : (w_ext >> fac.k);
    nh      = zoom_in ? (h_ext << fac.k) : (h_ext >> fac.k);
    // Replication iterates over source pixels, everything else over destination pixels
    unit_w  = (algo_sel == ALGO_REPL) ? w_ext : nw;
    unit_h  = (algo_sel == ALGO_REPL) ? h_ext : nh;
    // Replication writes start at cycle 2, block-average reads at cycle 0
    idx     = (algo_sel == ALGO_REPL) ? (cntr_q - 7'd2) : cntr_q;
    mask    = 7'(fac.f) - 7'd1;
    dx      = ADDR_W'(idx & mask);
    dy      = ADDR_W'(idx >> fac.k);
  end

  always_comb begin
    case (algo_sel)
      ALGO_BLK_AVG: rd_addr = ((row_q << fac.k) + dy) * w_ext + (col_q << fac.k) + dx;
      ALGO_NN_IN:   rd_addr = (row_q >> fac.k) * w_ext + (col_q >> fac.k);
      ALGO_NN_OUT:  rd_addr = (row_q << fac.k) * w_ext + (col_q << fac.k);
      default:      rd_addr = row_q * w_ext + col_q;
    endcase
    if (algo_sel == ALGO_REPL) wr_addr = ((row_q << fac.k) + dy) * nw + (col_q << fac.k) + dx;
    else                       wr_addr = row_q * nw + col_q;
  end

  always_comb begin
    zero_size = (nw == '0) || (nh == '0);
    last_unit = (row_q == unit_h - 1'b1) && (col_q == unit_w - 1'b1);
    row_d     = row_q;
    col_d     = col_q;
    cntr_d    = cntr_q;
    if (advance) begin
      cntr_d = '0;
      if (!last_unit) begin
        if (col_q == unit_w - 1'b1) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end else if (step) begin
      cntr_d = cntr_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      cntr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      cntr_q <= cntr_d;
    end
  end

  assign cntr    = cntr_q;
  assign shift_k = fac.k;
  assign row     = row_q;
  assign col     = col_q;

endmodule

// File: rtl/image_scale_core.sv
// Frame-level image rescaler: FSM, sample accumulate/capture and write datapath.
// Optional BLOCK_AVG_ROUND_EN: round-half-up block average instead of truncation.
module image_scale_core
  import image_scale_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          algo_sel,
  input  logic [1:0]          factor_in_sel,
  input  logic [1:0]          factor_out_sel,
  input  logic [9:0]          width,
  input  logic [9:0]          height,
  image_scale_core_if.master  mem,
  output logic [ADDR_W-1:0]   row,
  output logic [ADDR_W-1:0]   col,
  output logic                frame_done
);

  state_e      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [6:0]  cntr, n_sq, last_rd;
  logic [1:0]  shift_k;
  logic [2:0]  sh;
  logic [16:0] avg;
  logic        step, advance, last_unit, zero_size;

  scale_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk            (clk),
    .rst            (rst),
    .algo_sel       (algo_sel),
    .factor_in_sel  (factor_in_sel),
    .factor_out_sel (factor_out_sel),
    .width          (width),
    .height         (height),
    .step           (step),
    .advance        (advance),
    .cntr           (cntr),
    .shift_k        (shift_k),
    .row            (row),
    .col            (col),
    .rd_addr        (mem.rd_addr),
    .wr_addr        (mem.wr_addr),
    .last_unit      (last_unit),
    .zero_size      (zero_size)
  );

  // NEXT carries the unit's final write so the next unit starts without a gap
  always_comb begin
    sh      = {shift_k, 1'b0};
    n_sq    = 7'd1 << sh;
    last_rd = (algo_sel == ALGO_BLK_AVG) ? n_sq : 7'd1;
    state_d = state_q;
    sum_d   = sum_q;
    step    = 1'b0;
    advance = 1'b0;
    mem.wr_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (zero_size) begin
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
          if (cntr == 7'd1)
            sum_d = 16'(mem.rd_data);
          else if (cntr > 7'd1 && algo_sel == ALGO_BLK_AVG)
            sum_d = sum_q + 16'(mem.rd_data);
          if (cntr == last_rd)
            state_d = (algo_sel == ALGO_REPL) ? ST_WRITE : ST_NEXT;
        end
      end
      ST_WRITE: begin
        mem.wr_en = 1'b1;
        step      = 1'b1;
        if (cntr == n_sq) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        mem.wr_en = 1'b1;
        advance   = 1'b1;
        state_d   = last_unit ? ST_DONE : ST_RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
`ifdef BLOCK_AVG_ROUND_EN
    avg = ({1'b0, sum_q} + (17'd1 << (sh - 3'd1))) >> sh;
`else
    avg = {1'b0, sum_q} >> sh;
`endif
    mem.wr_data = (algo_sel == ALGO_BLK_AVG) ? PIX_W'(avg) : PIX_W'(sum_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end

  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_image_scale_core.sv
// Directed bench for image_scale_core on a 4x2 source image holding 1..8.
module tb_image_scale_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  algo_sel = 2'd0;
  logic [1:0]  factor_in_sel = 2'd0;
  logic [1:0]  factor_out_sel = 2'd0;
  logic [9:0]  width = 10'd4;
  logic [9:0]  height = 10'd2;
  logic [15:0] row, col;
  logic        frame_done;

  logic [7:0]  dst [0:255];
  int          wr_cnt, cyc, last_wr;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cycles;

  image_scale_core_if #(.ADDR_W(16), .PIX_W(8)) mem ();

  image_scale_core #(.ADDR_W(16), .PIX_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .algo_sel       (algo_sel),
    .factor_in_sel  (factor_in_sel),
    .factor_out_sel (factor_out_sel),
    .width          (width),
    .height         (height),
    .mem            (mem),
    .row            (row),
    .col            (col),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Source frame: pixel i holds i+1, one-cycle read latency
  always @(posedge clk)
    mem.rd_data <= (mem.rd_addr < 16'd8) ? 8'(mem.rd_addr + 16'd1) : 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= 0;
      cyc     <= 0;
      last_wr <= -1;
      for (int i = 0; i < 256; i++) dst[i] <= 8'hEE;
    end else begin
      cyc <= cyc + 1;
      if (mem.wr_en) begin
        wr_cnt  <= wr_cnt + 1;
        last_wr <= cyc;
        dst[mem.wr_addr[7:0]] <= mem.wr_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] a, input logic [1:0] fi, input logic [1:0] fo);
    @(negedge clk);
    rst = 1'b1;
    algo_sel = a;
    factor_in_sel = fi;
    factor_out_sel = fo;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!frame_done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_wr_en", 32'(mem.wr_en), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_rd_addr", 32'(mem.rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(mem.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(mem.wr_data), 32'd0);

    // Replication, Fi=2
    start_frame(2'd3, 2'b00, 2'b00);
    wait_done(cycles);
    chk("rep_done", 32'(frame_done), 32'd1);
    chk("rep_cycles", 32'(cycles), 32'd48);
    chk("rep_last_wr", 32'(last_wr), 32'd47);
    chk("rep_writes", 32'(wr_cnt), 32'd32);
    chk("rep_out0", 32'(dst[0]), 32'd1);
    chk("rep_out1", 32'(dst[1]), 32'd1);
    chk("rep_out8", 32'(dst[8]), 32'd1);
    chk("rep_out9", 32'(dst[9]), 32'd1);
    chk("rep_out2", 32'(dst[2]), 32'd2);
    chk("rep_out31", 32'(dst[31]), 32'd8);
    chk("rep_row", 32'(row), 32'd1);
    chk("rep_col", 32'(col), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("rep_done_sticky", 32'(frame_done), 32'd1);
    chk("rep_no_extra_wr", 32'(wr_cnt), 32'd32);

    // NN zoom-in, Fi=4
    start_frame(2'd1, 2'b01, 2'b00);
    wait_done(cycles);
    chk("nni_done", 32'(frame_done), 32'd1);
    chk("nni_cycles", 32'(cycles), 32'd384);
    chk("nni_writes", 32'(wr_cnt), 32'd128);
    for (int i = 0; i < 4; i++) chk("nni_out0_3", 32'(dst[i]), 32'd1);
    chk("nni_out4", 32'(dst[4]), 32'd2);
    chk("nni_out16", 32'(dst[16]), 32'd1);
    chk("nni_out64", 32'(dst[64]), 32'd5);
    chk("nni_out127", 32'(dst[127]), 32'd8);

    // NN zoom-out, Fo=2
    start_frame(2'd2, 2'b00, 2'b00);
    wait_done(cycles);
    chk("nno_done", 32'(frame_done), 32'd1);
    chk("nno_cycles", 32'(cycles), 32'd6);
    chk("nno_writes", 32'(wr_cnt), 32'd2);
    chk("nno_out0", 32'(dst[0]), 32'd1);
    chk("nno_out1", 32'(dst[1]), 32'd3);

    // Block average, Fo=2
    start_frame(2'd0, 2'b00, 2'b00);
    wait_done(cycles);
    chk("blk_done", 32'(frame_done), 32'd1);
    chk("blk_cycles", 32'(cycles), 32'd12);
    chk("blk_writes", 32'(wr_cnt), 32'd2);
`ifdef BLOCK_AVG_ROUND_EN
    chk("blk_out0", 32'(dst[0]), 32'd4);
    chk("blk_out1", 32'(dst[1]), 32'd6);
`else
    chk("blk_out0", 32'(dst[0]), 32'd3);
    chk("blk_out1", 32'(dst[1]), 32'd5);
`endif

    // Zero-size destination: Fo=8 on a 4-wide source
    start_frame(2'd2, 2'b00, 2'b10);
    wait_done(cycles);
    chk("zero_done", 32'(frame_done), 32'd1);
    chk("zero_cycles", 32'(cycles), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_writes", 32'(wr_cnt), 32'd0);
    chk("zero_done_sticky", 32'(frame_done), 32'd1);

    // Reset pulsed mid-frame during replication
    start_frame(2'd3, 2'b00, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_wr_en_before", 32'(mem.wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_wr_en_rst", 32'(mem.wr_en), 32'd0);
    chk("mid_done_rst", 32'(frame_done), 32'd0);
    chk("mid_row_rst", 32'(row), 32'd0);
    chk("mid_col_rst", 32'(col), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(cycles);
    chk("mid_done", 32'(frame_done), 32'd1);
    chk("mid_cycles", 32'(cycles), 32'd48);
    chk("mid_writes", 32'(wr_cnt), 32'd32);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        chk("mid_pixel", 32'(dst[r*8+c]), 32'((r >> 1) * 4 + (c >> 1) + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
